// File: rtl/pc_gen_pkg.sv
// Shared encodings for the fetch-PC generator: redirect sources, FSM states, priority ranking.
package pc_gen_pkg;

   localparam int unsigned SRC_W = 3;

   localparam logic [SRC_W-1:0] SRC_SEQ  = 3'd0;
   localparam logic [SRC_W-1:0] SRC_BR   = 3'd1;
   localparam logic [SRC_W-1:0] SRC_JR   = 3'd2;
   localparam logic [SRC_W-1:0] SRC_ERET = 3'd3;
   localparam logic [SRC_W-1:0] SRC_EXC  = 3'd4;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_PEND = 1'b1;

   // Higher rank wins; sequential fetch ranks lowest so any redirect beats an empty latch.
   function automatic logic [SRC_W-1:0] src_rank(input logic [SRC_W-1:0] src);
      logic [SRC_W-1:0] rank;
      case (src)
         SRC_EXC:  rank = 3'd4;
         SRC_ERET: rank = 3'd3;
         SRC_JR:   rank = 3'd2;
         SRC_BR:   rank = 3'd1;
         default:  rank = 3'd0;
      endcase
      return rank;
   endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect that arrived during a stall; a strictly higher-priority one may replace it.
module pc_redirect_latch
   import pc_gen_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             merge,
   input  logic             clr,
   input  logic [2:0]       req_src,
   input  logic [WIDTH-1:0] req_target,
   output logic [WIDTH-1:0] lat_target
);

   logic [SRC_W-1:0] lat_src_q;
   logic [WIDTH-1:0] lat_target_q;
   logic             upgrade_c;

   // A merge only takes effect when the new request strictly outranks the latched one.
   always_comb begin
      upgrade_c = 1'b0;
      if (src_rank(req_src) > src_rank(lat_src_q)) upgrade_c = 1'b1;
   end

   // Latched source/target storage; clear discards the redirect once applied or preempted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_src_q    <= SRC_SEQ;
         lat_target_q <= '0;
      end else if (clr) begin
         lat_src_q    <= SRC_SEQ;
         lat_target_q <= '0;
      end else if (load || (merge && upgrade_c)) begin
         lat_src_q    <= req_src;
         lat_target_q <= req_target;
      end
   end

   assign lat_target = lat_target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: PC register, prioritized next-PC mux, stall redirect FSM, misalignment trap.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = 'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_VECTOR = 'h0000_4180,
   parameter int unsigned     STEP       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jr_valid,
   input  logic [WIDTH-1:0] jr_target,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic             pending,
   output logic             adel_fetch
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             pending_q, pending_d;
   logic             adel_q, adel_d;

   logic [SRC_W-1:0] win_src;
   logic [WIDTH-1:0] win_target;
   logic [WIDTH-1:0] lat_target;
   logic [WIDTH-1:0] apply_tgt;
   logic             do_apply;
   logic             lat_load, lat_merge, lat_clr;

   // Pick this cycle's winning redirect among the non-exception sources.
   always_comb begin
      win_src    = SRC_SEQ;
      win_target = '0;
      if (eret_req) begin
         win_src    = SRC_ERET;
         win_target = epc;
      end else if (jr_valid) begin
         win_src    = SRC_JR;
         win_target = jr_target;
      end else if (br_valid) begin
         win_src    = SRC_BR;
         win_target = br_target;
      end
   end

   pc_redirect_latch #(.WIDTH(WIDTH)) u_latch (
      .clk        (clk),
      .reset      (reset),
      .load       (lat_load),
      .merge      (lat_merge),
      .clr        (lat_clr),
      .req_src    (win_src),
      .req_target (win_target),
      .lat_target (lat_target)
   );

   // Next-state, next-PC and latch control; exceptions override everything, including stall.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      adel_d    = 1'b0;
      lat_load  = 1'b0;
      lat_merge = 1'b0;
      lat_clr   = 1'b0;
      do_apply  = 1'b0;
      apply_tgt = '0;

      if (exc_req) begin
         pc_d    = EXC_VECTOR;
         lat_clr = 1'b1;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  if (win_src == SRC_SEQ) begin
                     pc_d = pc_q + WIDTH'(STEP);
                  end else begin
                     do_apply  = 1'b1;
                     apply_tgt = win_target;
                  end
               end else if (win_src != SRC_SEQ) begin
                  lat_load = 1'b1;
                  state_d  = ST_PEND;
               end
            end
            ST_PEND: begin
               if (en) begin
                  // The latched redirect belongs to the older instruction, so new ones are dropped.
                  do_apply  = 1'b1;
                  apply_tgt = lat_target;
                  lat_clr   = 1'b1;
                  state_d   = ST_IDLE;
               end else if (win_src != SRC_SEQ) begin
                  lat_merge = 1'b1;
               end
            end
            default: begin
               lat_clr = 1'b1;
               state_d = ST_IDLE;
            end
         endcase

         // Alignment is checked only when a redirect is actually applied.
         if (do_apply) begin
            if (apply_tgt[1:0] != 2'b00) begin
               pc_d   = EXC_VECTOR;
               adel_d = 1'b1;
            end else begin
               pc_d = apply_tgt;
            end
         end
      end

      pending_d = (state_d == ST_PEND);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_ADDR;
         pending_q <= 1'b0;
         adel_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
         adel_q    <= adel_d;
      end
   end

   assign pc         = pc_q;
   assign pending    = pending_q;
   assign adel_fetch = adel_q;

endmodule
